rv32_instr_enc: RTL and testbench



---
 rtl/rv32_instr_enc.sv | 180 ++++++++++++++++++
 tb/tb_rv32_instr_enc.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_instr_enc.sv
// rv32_instr_enc: two-stage RV32I instruction packer.
// Stage 1 latches a decoded request and its immediate-range verdict.
// Stage 2 latches the packed word and error flag and drives the outputs.
// Backpressure ripples combinationally from out_ready through both stages.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

module rv32_instr_enc #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_fmt,
  input  logic [6:0]          in_opcode,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic [2:0]          in_funct3,
  input  logic [6:0]          in_funct7,
  input  logic [`XPR_LEN-1:0] in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [`XPR_LEN-1:0] out_instr,
  output logic                out_err,
  output logic [CNT_W-1:0]    enc_cnt,
  output logic [CNT_W-1:0]    err_cnt
);
  localparam int XL = `XPR_LEN;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_CSRI = 3'd6,
    FMT_RSV  = 3'd7
  } fmt_e;

  logic          s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic          s1_rdy, s2_rdy, fire;
  fmt_e          in_fmt_e, s1_fmt_q;
  logic [6:0]    s1_op_q, s1_f7_q;
  logic [4:0]    s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [2:0]    s1_f3_q;
  logic [XL-1:0] s1_imm_q;
  logic          s1_err_q, in_err;
  logic          fits12, fits13, fits21;
  logic [XL-1:0] pack_word, s2_instr_q;
  logic          s2_err_q;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d, err_cnt_q, err_cnt_d;

  assign s2_rdy    = !s2_v_q || out_ready;
  assign s1_rdy    = !s1_v_q || s2_rdy;
  assign in_ready  = s1_rdy;
  assign fire      = s2_v_q && out_ready;
  assign in_fmt_e  = fmt_e'(in_fmt);

  assign out_valid = s2_v_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign enc_cnt   = enc_cnt_q;
  assign err_cnt   = err_cnt_q;

  // A value fits an N-bit signed field when all bits above N-1 copy the sign.
  assign fits12 = (&in_imm[XL-1:11]) || !(|in_imm[XL-1:11]);
  assign fits13 = (&in_imm[XL-1:12]) || !(|in_imm[XL-1:12]);
  assign fits21 = (&in_imm[XL-1:20]) || !(|in_imm[XL-1:20]);

  // Range check on the incoming immediate, captured with the request.
  always_comb begin
    in_err = 1'b0;
    case (in_fmt_e)
      FMT_R:          in_err = 1'b0;
      FMT_I, FMT_S:   in_err = !fits12;
      FMT_B:          in_err = !fits13 || in_imm[0];
      FMT_U:          in_err = |in_imm[11:0];
      FMT_J:          in_err = !fits21 || in_imm[0];
      FMT_CSRI:       in_err = |in_imm[XL-1:5];
      default:        in_err = 1'b1;
    endcase
  end

  // Stage valids advance whenever the stage ahead can take their contents.
  always_comb begin
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;
    if (s1_rdy) s1_v_d = in_valid;
    if (s2_rdy) s2_v_d = s1_v_q;
  end

  // Stage 1: capture an accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_fmt_q <= FMT_R;
      s1_op_q  <= '0;
      s1_f7_q  <= '0;
      s1_rd_q  <= '0;
      s1_rs1_q <= '0;
      s1_rs2_q <= '0;
      s1_f3_q  <= '0;
      s1_imm_q <= '0;
      s1_err_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      if (s1_rdy && in_valid) begin
        s1_fmt_q <= in_fmt_e;
        s1_op_q  <= in_opcode;
        s1_f7_q  <= in_funct7;
        s1_rd_q  <= in_rd;
        s1_rs1_q <= in_rs1;
        s1_rs2_q <= in_rs2;
        s1_f3_q  <= in_funct3;
        s1_imm_q <= in_imm;
        s1_err_q <= in_err;
      end
    end
  end

  // Scatter the immediate bits into their format-specific slots.
  always_comb begin
    pack_word = '0;
    case (s1_fmt_q)
      FMT_R:    pack_word = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_I:    pack_word = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_S:    pack_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                             s1_imm_q[4:0], s1_op_q};
      FMT_B:    pack_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                             s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      FMT_U:    pack_word = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
      FMT_J:    pack_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                             s1_imm_q[19:12], s1_rd_q, s1_op_q};
      // The csr address travels in {funct7, rs2}; the uimm sits in the rs1 slot.
      FMT_CSRI: pack_word = {s1_f7_q, s1_rs2_q, s1_imm_q[4:0], s1_f3_q, s1_rd_q, s1_op_q};
      default:  pack_word = '0;
    endcase
  end

  // Stage 2: capture the packed word; it holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_q     <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s2_v_q <= s2_v_d;
      if (s2_rdy && s1_v_q) begin
        s2_instr_q <= pack_word;
        s2_err_q   <= s1_err_q;
      end
    end
  end

  // Output statistics: encode count wraps, error count saturates.
  always_comb begin
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (fire) begin
      enc_cnt_d = enc_cnt_q + CNT_W'(1);
      if (s2_err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_rv32_instr_enc.sv
// Bench for rv32_instr_enc: directed encodings, error cases, counter
// wrap/saturation, backpressure, async reset and a random round trip
// checked by decoding the emitted word back with the immediate generator.
module tb_rv32_instr_enc;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = '0;
  logic [6:0]    in_opcode = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [CW-1:0] enc_cnt, err_cnt;

  rv32_instr_enc #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .enc_cnt(enc_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  req_t sb_q[$];
  req_t stim_q[$];
  int checks = 0, failures = 0;
  int n_out = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input int fmt, input int op, input int rd, input int rs1,
                              input int rs2, input int f3, input int f7, input logic [31:0] imm);
    req_t r;
    r.fmt = 3'(fmt); r.op = 7'(op); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
    r.f3 = 3'(f3); r.f7 = 7'(f7); r.imm = imm;
    return r;
  endfunction

  // Error verdict from the signed ranges of each format.
  function automatic bit model_err(input req_t r);
    int s;
    s = $signed(r.imm);
    case (r.fmt)
      3'd0: return 1'b0;
      3'd1, 3'd2: return (s < -2048) || (s > 2047);
      3'd3: return (s < -4096) || (s > 4094) || (s % 2 != 0);
      3'd4: return (r.imm % 4096) != 0;
      3'd5: return (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      3'd6: return r.imm > 32'd31;
      default: return 1'b1;
    endcase
  endfunction

  // Immediate generator: what a decoder recovers from an instruction word.
  function automatic logic [31:0] dec_imm(input logic [2:0] fmt, input logic [31:0] w);
    case (fmt)
      3'd1: return {{20{w[31]}}, w[31:20]};
      3'd2: return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4: return {w[31:12], 12'b0};
      3'd5: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      3'd6: return {27'b0, w[19:15]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_word(input req_t r, input logic [31:0] w, input logic e, input string tag);
    bit ee;
    ee = model_err(r);
    chk({tag, "_err"}, 32'(e), 32'(ee));
    if (r.fmt == 3'd7) begin
      chk({tag, "_rsv_word"}, w, 32'd0);
    end else begin
      chk({tag, "_opcode"}, 32'(w[6:0]), 32'(r.op));
      if (r.fmt inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6}) chk({tag, "_rd"}, 32'(w[11:7]), 32'(r.rd));
      if (r.fmt inside {3'd0, 3'd1, 3'd2, 3'd3}) chk({tag, "_rs1"}, 32'(w[19:15]), 32'(r.rs1));
      if (r.fmt inside {3'd0, 3'd2, 3'd3}) chk({tag, "_rs2"}, 32'(w[24:20]), 32'(r.rs2));
      if (r.fmt inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd6}) chk({tag, "_f3"}, 32'(w[14:12]), 32'(r.f3));
      if (r.fmt == 3'd0) chk({tag, "_f7"}, 32'(w[31:25]), 32'(r.f7));
      if (r.fmt == 3'd6) chk({tag, "_csr"}, 32'(w[31:20]), 32'({r.f7, r.rs2}));
      if (!ee && r.fmt != 3'd0) chk({tag, "_roundtrip"}, dec_imm(r.fmt, w), r.imm);
    end
  endtask

  task automatic drive(input req_t r);
    in_fmt = r.fmt; in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
    in_funct3 = r.f3; in_funct7 = r.f7; in_imm = r.imm;
  endtask

  task automatic load_inputs(input bit rnd);
    if (stim_q.size() > 0) begin
      drive(stim_q[0]);
      in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    if (rnd) out_ready = ($urandom_range(0, 2) != 0);
  endtask

  // One clock: observe handshakes at the falling edge, drive after the rising edge.
  task automatic step(input bit rnd, input string tag);
    req_t r;
    @(negedge clk);
    if (out_valid && out_ready) begin
      chk({tag, "_expected_output"}, 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        r = sb_q.pop_front();
        check_word(r, out_instr, out_err, tag);
      end
      n_out++;
      if (out_err) n_err++;
    end
    if (in_valid && in_ready) sb_q.push_back(stim_q.pop_front());
    @(posedge clk);
    #1;
    load_inputs(rnd);
  endtask

  task automatic check_cnt(input string tag);
    chk({tag, "_enc_cnt"}, 32'(enc_cnt), 32'(n_out % (1 << CW)));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'((n_err > (1 << CW) - 1) ? (1 << CW) - 1 : n_err));
  endtask

  // Single request into an idle pipeline; checks latency and, optionally, the exact word.
  task automatic directed(input req_t r, input bit has_w, input logic [31:0] exp_w, input string tag);
    int k, edges;
    drive(r);
    in_valid = 1'b1;
    out_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    edges = 1;
    @(negedge clk);
    while (!out_valid && edges < 10) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(edges), 32'd2);
    check_word(r, out_instr, out_err, tag);
    if (has_w) chk({tag, "_word"}, out_instr, exp_w);
    if (out_valid) begin
      n_out++;
      if (out_err) n_err++;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic req_t rand_req();
    req_t r;
    r = mk($urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7),
           $urandom_range(0, 127), 32'd0);
    case (r.fmt)
      3'd1, 3'd2: r.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      3'd3: r.imm = (32'($urandom_range(0, 4095)) - 32'd2048) * 32'd2;
      3'd4: r.imm = $urandom & 32'hFFFF_F000;
      3'd5: r.imm = (32'($urandom_range(0, 1048575)) - 32'd524288) * 32'd2;
      3'd6: r.imm = 32'($urandom_range(0, 31));
      default: r.imm = $urandom;
    endcase
    if ($urandom_range(0, 9) == 0) r.imm = $urandom;
    return r;
  endfunction

  initial begin
    logic [31:0] w0;
    logic e0;
    int bound, base;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_enc_cnt", 32'(enc_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed encodings.
    directed(mk(1, 7'b0010011, 1, 0, 0, 0, 0, 32'hFFFF_FFFF), 1'b1, 32'hFFF0_0093, "addi");
    directed(mk(3, 7'b1100011, 0, 1, 2, 0, 0, -32'sd4), 1'b1, 32'hFE20_8EE3, "beq");
    directed(mk(2, 7'b0100011, 0, 1, 2, 2, 0, 32'd8), 1'b1, 32'h0020_A423, "sw");
    directed(mk(4, 7'b0110111, 5, 0, 0, 0, 0, 32'h1234_5000), 1'b1, 32'h1234_52B7, "lui");

    // Immediate errors and reserved format.
    directed(mk(3, 7'b1100011, 0, 3, 4, 1, 0, 32'd3), 1'b0, 32'd0, "b_odd");
    directed(mk(1, 7'b0010011, 2, 3, 0, 0, 0, 32'd2048), 1'b0, 32'd0, "i_2048");
    directed(mk(4, 7'b0110111, 6, 0, 0, 0, 0, 32'h1234_5001), 1'b0, 32'd0, "u_low");
    directed(mk(7, 7'b1111111, 7, 7, 7, 7, 7, 32'h5555_5555), 1'b1, 32'd0, "rsv");
    chk("after_errors_err_cnt", 32'(err_cnt), 32'd4);
    chk("after_errors_enc_cnt", 32'(enc_cnt), 32'd8);

    // Boundary immediates that must still fit.
    directed(mk(1, 7'b0010011, 9, 8, 0, 0, 0, -32'sd2048), 1'b0, 32'd0, "i_min");
    directed(mk(3, 7'b1100011, 0, 8, 9, 5, 0, 32'd4094), 1'b0, 32'd0, "b_max");
    directed(mk(5, 7'b1101111, 1, 0, 0, 0, 0, -32'sd1048576), 1'b0, 32'd0, "j_min");
    directed(mk(6, 7'b1110011, 3, 0, 5, 5, 7'h61, 32'd31), 1'b0, 32'd0, "csri");
    directed(mk(5, 7'b1101111, 1, 0, 0, 0, 0, 32'd1048576), 1'b0, 32'd0, "j_over");

    // Drive counters past wrap and saturation with back-to-back reserved formats.
    for (int i = 0; i < 14; i++) stim_q.push_back(mk(7, 0, i, 0, 0, 0, 0, 32'd0));
    out_ready = 1'b1;
    load_inputs(1'b0);
    bound = 0;
    while ((stim_q.size() > 0 || sb_q.size() > 0) && bound < 60) begin
      step(1'b0, "sat");
      bound++;
    end
    chk("sat_drain", 32'(bound < 60), 32'd1);
    check_cnt("sat");
    chk("sat_err_cnt_const", 32'(err_cnt), 32'd15);

    // Backpressure: four requests offered while the consumer stalls.
    base = n_out;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      stim_q.push_back(mk(1, 7'b0010011, 10 + i, i, 0, 0, 0, 32'(100 * (i + 1))));
    load_inputs(1'b0);
    step(1'b0, "bp");
    step(1'b0, "bp");
    w0 = out_instr;
    e0 = out_err;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, "bp");
      chk("bp_stable_valid", 32'(out_valid), 32'd1);
      chk("bp_stable_instr", out_instr, w0);
      chk("bp_stable_err", 32'(out_err), 32'(e0));
    end
    chk("bp_accepted", 32'(sb_q.size()), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    bound = 0;
    while ((stim_q.size() > 0 || sb_q.size() > 0) && bound < 30) begin
      step(1'b0, "bp");
      bound++;
    end
    chk("bp_delivered", 32'(n_out - base), 32'd4);
    check_cnt("bp");

    // Async reset with both stages full.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) stim_q.push_back(mk(4, 7'b0110111, 20 + i, 0, 0, 0, 0, 32'hABCD_E000));
    load_inputs(1'b0);
    repeat (4) step(1'b0, "mid");
    chk("mid_full", 32'(sb_q.size()), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_instr", out_instr, 32'd0);
    chk("mid_rst_out_err", 32'(out_err), 32'd0);
    chk("mid_rst_enc_cnt", 32'(enc_cnt), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    in_valid = 1'b0;
    sb_q.delete();
    stim_q.delete();
    n_out = 0;
    n_err = 0;
    out_ready = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    directed(mk(1, 7'b0010011, 1, 0, 0, 0, 0, 32'hFFFF_FFFF), 1'b1, 32'hFFF0_0093, "post_rst");
    check_cnt("post_rst");

    // Random round trip with random valid and ready toggling.
    base = n_out;
    for (int i = 0; i < 10000; i++) stim_q.push_back(rand_req());
    load_inputs(1'b1);
    bound = 0;
    while ((stim_q.size() > 0 || sb_q.size() > 0) && bound < 60000) begin
      step(1'b1, "rnd");
      bound++;
    end
    chk("rnd_no_timeout", 32'(bound < 60000), 32'd1);
    chk("rnd_delivered", 32'(n_out - base), 32'd10000);
    check_cnt("rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
